// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Brief    : Parametrised register file with NUM_RD combinational read ports,
//             optional write-through bypass and a per-register pending-write
//             scoreboard that raises a stall (hazard) on RAW dependencies and
//             on WAW counter saturation.
//  Options  : REGFILE_BYPASS_EN - when defined, writeback data is forwarded
//             to readers in the same cycle and the retiring write no longer
//             counts as pending for them.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int NUM_RD   = 2,
   parameter int MAX_PEND = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       issue_valid,
   input  logic                       issue_wen,
   input  logic [ADDR_W-1:0]          issue_dest,
   output logic                       issue_accept,
   output logic                       hazard,
   input  logic                       wb_en,
   input  logic [ADDR_W-1:0]          wb_addr,
   input  logic [DATA_W-1:0]          wb_data,
   input  logic [ADDR_W-1:0]          mon_addr,
   output logic [DATA_W-1:0]          mon_data,
   output logic                       err_underflow
);

   localparam int c_NREG = 2 ** ADDR_W;
   localparam int c_CW   = $clog2(MAX_PEND + 1);

   logic [DATA_W-1:0] r_regs [c_NREG];
   logic [c_CW-1:0]   r_cnt  [c_NREG];
   logic              r_err;

   logic w_inc_any;     // an accepted writing instruction targets issue_dest
   logic w_wb_live;     // writeback to a real (non-R0) register
   logic w_dec_dest;    // writeback retires a write to issue_dest this cycle
   logic w_raw;
   logic w_waw;
   logic w_underflow;

   assign w_inc_any  = issue_accept & issue_wen;
   assign w_wb_live  = wb_en & (wb_addr != '0);
   assign w_dec_dest = wb_en & (wb_addr == issue_dest);

   // Retiring a write with nothing pending is an error, unless an issue to
   // the same register lands in the same cycle (net counter change is zero).
   assign w_underflow = w_wb_live & (r_cnt[wb_addr] == '0) &
                        ~(w_inc_any & (issue_dest == wb_addr));

   // Register array: cleared on reset, R0 is never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < c_NREG; r++) r_regs[r] <= '0;
      end else if (w_wb_live) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   // Pending-write counters: +1 on accepted issue, -1 on writeback, hold on both.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < c_NREG; r++) r_cnt[r] <= '0;
      end else begin
         r_cnt[0] <= '0;
         for (int r = 1; r < c_NREG; r++) begin
            if (w_inc_any && issue_dest == ADDR_W'(r) &&
                !(wb_en && wb_addr == ADDR_W'(r))) begin
               r_cnt[r] <= r_cnt[r] + c_CW'(1);
            end else if (wb_en && wb_addr == ADDR_W'(r) &&
                         !(w_inc_any && issue_dest == ADDR_W'(r)) &&
                         r_cnt[r] != '0) begin
               r_cnt[r] <= r_cnt[r] - c_CW'(1);
            end
         end
      end
   end

   // Sticky underflow flag, only cleared by reset.
   always_ff @(posedge clk) begin
      if (rst)              r_err <= 1'b0;
      else if (w_underflow) r_err <= 1'b1;
   end

   assign err_underflow = r_err;
   assign mon_data      = r_regs[mon_addr];

   generate
      for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
         logic [ADDR_W-1:0] w_addr;
         assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
         logic w_hit;
         assign w_hit = wb_en & (wb_addr == w_addr);
         // A bypass hit retires one pending write; a hit on an empty counter
         // is an underflow writeback and must not wrap into a busy result.
         assign rd_data[i*DATA_W +: DATA_W] = (w_addr == '0) ? '0 :
                                              w_hit ? wb_data : r_regs[w_addr];
         assign rd_busy[i] = (w_addr != '0) &
                             (w_hit ? (r_cnt[w_addr] > c_CW'(1))
                                    : (r_cnt[w_addr] != '0));
`else
         assign rd_data[i*DATA_W +: DATA_W] = (w_addr == '0) ? '0 : r_regs[w_addr];
         assign rd_busy[i] = (w_addr != '0) & (r_cnt[w_addr] != '0);
`endif
      end
   endgenerate

   // WAW saturation blocks issue instead of letting the counter wrap.
   assign w_raw = |(rd_en & rd_busy);
   assign w_waw = issue_wen & (issue_dest != '0) &
                  (r_cnt[issue_dest] == c_CW'(MAX_PEND)) & ~w_dec_dest;

   assign hazard       = issue_valid & (w_raw | w_waw);
   assign issue_accept = issue_valid & ~hazard;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_scoreboard
//  Brief    : Directed self-checking bench for regfile_scoreboard. Expected
//             values follow the REGFILE_BYPASS_EN setting of the build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int NUM_RD = 2;
`ifdef REGFILE_BYPASS_EN
   localparam bit c_BYP = 1'b1;
`else
   localparam bit c_BYP = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     issue_valid;
   logic                     issue_wen;
   logic [ADDR_W-1:0]        issue_dest;
   logic                     issue_accept;
   logic                     hazard;
   logic                     wb_en;
   logic [ADDR_W-1:0]        wb_addr;
   logic [DATA_W-1:0]        wb_data;
   logic [ADDR_W-1:0]        mon_addr;
   logic [DATA_W-1:0]        mon_data;
   logic                     err_underflow;

   int n_pass  = 0;
   int n_total = 0;

   regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .MAX_PEND(3)) dut (
      .clk(clk), .rst(rst),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_dest(issue_dest),
      .issue_accept(issue_accept), .hazard(hazard),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .mon_addr(mon_addr), .mon_data(mon_data), .err_underflow(err_underflow)
   );

   // 20 ns clock
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_en = '0; rd_addr = '0;
      issue_valid = 1'b0; issue_wen = 1'b0; issue_dest = '0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
   endtask

   task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                         input logic [NUM_RD-1:0] en);
      rd_addr = {a1, a0};
      rd_en   = en;
   endtask

   task automatic issue(input logic wen, input logic [ADDR_W-1:0] dest);
      issue_valid = 1'b1; issue_wen = wen; issue_dest = dest;
   endtask

   task automatic wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
   endtask

   initial begin
      idle();
      mon_addr = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // ---- reset state: every register reads 0, nothing busy -------------
      issue(1'b0, 3'd0);
      for (int r = 1; r < 8; r++) begin
         set_rd(ADDR_W'(r), ADDR_W'(r), 2'b11);
         #1;
         check("rst_rd0", {16'h0, rd_data[15:0]}, 32'h0);
         check("rst_rd1", {16'h0, rd_data[31:16]}, 32'h0);
         check("rst_busy", {30'h0, rd_busy}, 32'h0);
         check("rst_hazard", {31'h0, hazard}, 32'h0);
      end
      check("rst_err", {31'h0, err_underflow}, 32'h0);
      check("rst_mon", {16'h0, mon_data}, 32'h0);
      tick();

      // ---- RAW stall on R3 -------------------------------------------------
      idle();
      issue(1'b1, 3'd3);
      #2;
      check("raw_issue_acc", {31'h0, issue_accept}, 32'h1);
      tick();
      idle();
      issue(1'b0, 3'd0);
      set_rd(3'd3, 3'd0, 2'b01);
      #2;
      check("raw_haz1", {31'h0, hazard}, 32'h1);
      check("raw_acc1", {31'h0, issue_accept}, 32'h0);
      check("raw_busy1", {31'h0, rd_busy[0]}, 32'h1);
      tick();
      #2;
      check("raw_haz2", {31'h0, hazard}, 32'h1);
      wb(3'd3, 16'h00A5);
      #2;
      check("raw_wb_haz", {31'h0, hazard}, c_BYP ? 32'h0 : 32'h1);
      check("raw_wb_acc", {31'h0, issue_accept}, c_BYP ? 32'h1 : 32'h0);
      check("raw_wb_data", {16'h0, rd_data[15:0]}, c_BYP ? 32'h00A5 : 32'h0);
      tick();
      wb_en = 1'b0;
      set_rd(3'd3, 3'd3, 2'b11);
      #2;
      check("raw_after_haz", {31'h0, hazard}, 32'h0);
      check("raw_after_d0", {16'h0, rd_data[15:0]}, 32'h00A5);
      check("raw_after_d1", {16'h0, rd_data[31:16]}, 32'h00A5);
      check("raw_after_busy", {30'h0, rd_busy}, 32'h0);

      // ---- WAW saturation on R5 -------------------------------------------
      idle();
      issue(1'b1, 3'd5);
      for (int k = 0; k < 3; k++) begin
         #2;
         check("sat_acc", {31'h0, issue_accept}, 32'h1);
         tick();
      end
      #2;
      check("sat_haz", {31'h0, hazard}, 32'h1);
      check("sat_block", {31'h0, issue_accept}, 32'h0);
      wb(3'd5, 16'h0055);
      #2;
      check("sat_wb_haz", {31'h0, hazard}, 32'h0);
      check("sat_wb_acc", {31'h0, issue_accept}, 32'h1);
      tick();
      wb_en = 1'b0;
      set_rd(3'd5, 3'd0, 2'b00);
      #2;
      check("sat_still_full", {31'h0, hazard}, 32'h1);
      check("sat_busy", {31'h0, rd_busy[0]}, 32'h1);
      issue_valid = 1'b0;
      wb(3'd5, 16'h0055);
      tick(); tick(); tick();
      wb_en = 1'b0;
      #2;
      check("sat_drained_busy", {31'h0, rd_busy[0]}, 32'h0);
      check("sat_no_err", {31'h0, err_underflow}, 32'h0);

      // ---- simultaneous issue + writeback on R2 ---------------------------
      idle();
      issue(1'b1, 3'd2);
      tick();
      wb(3'd2, 16'h2222);
      #2;
      check("sim_acc", {31'h0, issue_accept}, 32'h1);
      tick();
      idle();
      set_rd(3'd2, 3'd0, 2'b00);
      #2;
      check("sim_busy", {31'h0, rd_busy[0]}, 32'h1);
      check("sim_data", {16'h0, rd_data[15:0]}, 32'h2222);
      wb(3'd2, 16'h2223);
      tick();
      wb_en = 1'b0;
      #2;
      check("sim_drained", {31'h0, rd_busy[0]}, 32'h0);
      check("sim_no_err", {31'h0, err_underflow}, 32'h0);

      // ---- R0 is hardwired, then underflow on R4 --------------------------
      idle();
      issue(1'b1, 3'd0);
      wb(3'd0, 16'hFFFF);
      set_rd(3'd0, 3'd0, 2'b11);
      #2;
      check("r0_acc", {31'h0, issue_accept}, 32'h1);
      check("r0_data_byp", {16'h0, rd_data[15:0]}, 32'h0);
      tick();
      idle();
      set_rd(3'd0, 3'd0, 2'b11);
      mon_addr = 3'd0;
      #2;
      check("r0_data", {16'h0, rd_data[31:16]}, 32'h0);
      check("r0_busy", {30'h0, rd_busy}, 32'h0);
      check("r0_mon", {16'h0, mon_data}, 32'h0);
      check("r0_no_err", {31'h0, err_underflow}, 32'h0);
      wb(3'd4, 16'h4444);
      tick();
      idle();
      #2;
      check("uf_set", {31'h0, err_underflow}, 32'h1);
      tick(); tick(); tick();
      set_rd(3'd4, 3'd0, 2'b01);
      #2;
      check("uf_sticky", {31'h0, err_underflow}, 32'h1);
      check("uf_cnt_zero", {31'h0, rd_busy[0]}, 32'h0);
      check("uf_data", {16'h0, rd_data[15:0]}, 32'h4444);

      // ---- monitor port vs bypassed read of R6 ----------------------------
      idle();
      issue(1'b1, 3'd6);
      tick();
      issue(1'b1, 3'd0);
      issue_wen = 1'b0;
      set_rd(3'd0, 3'd6, 2'b10);
      mon_addr = 3'd6;
      wb(3'd6, 16'h1234);
      #2;
      check("mon_wb_cycle", {16'h0, mon_data}, 32'h0);
      check("mon_rd_haz", {31'h0, hazard}, c_BYP ? 32'h0 : 32'h1);
      check("mon_rd_data", {16'h0, rd_data[31:16]}, c_BYP ? 32'h1234 : 32'h0);
      check("mon_rd_busy", {31'h0, rd_busy[1]}, c_BYP ? 32'h0 : 32'h1);
      tick();
      wb_en = 1'b0;
      #2;
      check("mon_next", {16'h0, mon_data}, 32'h1234);
      check("mon_rd_next", {16'h0, rd_data[31:16]}, 32'h1234);
      check("mon_haz_next", {31'h0, hazard}, 32'h0);

      // ---- reset mid-operation discards pending writes --------------------
      idle();
      issue(1'b1, 3'd7);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_rd(3'd7, 3'd3, 2'b11);
      #2;
      check("mrst_err", {31'h0, err_underflow}, 32'h0);
      check("mrst_busy", {30'h0, rd_busy}, 32'h0);
      check("mrst_data3", {16'h0, rd_data[31:16]}, 32'h0);
      check("mrst_mon", {16'h0, mon_data}, 32'h0);
      wb(3'd7, 16'h7777);
      tick();
      idle();
      #2;
      check("mrst_uf", {31'h0, err_underflow}, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
